// File: rtl/lmdpl_pkg.sv
// Shared definitions for the LMDPL evaluation sequencer: FSM state
// encoding, default evaluation length and eval-counter sizing.
package lmdpl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRECH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Number of evaluation cycles that follow the single precharge cycle.
  localparam int unsigned EVAL_CYCLES_DEFAULT = 3;

  // Eval counter is wide enough for the legal range 1..15.
  localparam int unsigned EVAL_CNT_W = 4;

  // Value loaded into the eval counter on PRECH -> EVAL.
  function automatic logic [EVAL_CNT_W-1:0] eval_load(input int unsigned cycles);
    return EVAL_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lmdpl_eval_sequencer.sv
// Sequences one masked LMDPL gate evaluation per accepted operand pair:
// latch operands and PRNG masks, precharge for one cycle, evaluate for
// EVAL_CYCLES cycles, capture the masked result and hold it until taken.
module lmdpl_eval_sequencer
  import lmdpl_pkg::*;
#(
  parameter int unsigned EVAL_CYCLES = EVAL_CYCLES_DEFAULT,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in0_data,
  input  logic             in1_data,
  input  logic [31:0]      prng_in,
  output logic             gate_in0,
  output logic             gate_in1,
  output logic             m_in0,
  output logic             m_in1,
  output logic             m_out,
  output logic             precharge,
  input  logic             gate_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic             out_masked,
  output logic             out_mask,
  output logic [CNT_W-1:0] txn_count
);

  localparam logic [EVAL_CNT_W-1:0] LP_EVAL_LOAD = eval_load(EVAL_CYCLES);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [EVAL_CNT_W-1:0] r_eval_cnt;
  logic                  r_precharge;
  logic                  r_gate_in0;
  logic                  r_gate_in1;
  logic                  r_m_in0;
  logic                  r_m_in1;
  logic                  r_m_out;
  logic                  r_out_masked;
  logic                  r_out_mask;
  logic [CNT_W-1:0]      r_txn_count;

  logic                  w_accept;
  logic                  w_load_eval;
  logic                  w_capture;
  logic                  w_retire;

  // Only the low three PRNG bits are used as masks.
  logic                  w_prng_unused;
  assign w_prng_unused = ^prng_in[31:3];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_load_eval = 1'b0;
    w_capture   = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = PRECH;
        end
      end
      PRECH: begin
        w_load_eval = 1'b1;
        w_state_nxt = EVAL;
      end
      EVAL: begin
        if (r_eval_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_retire    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Precharge strobe is registered off the next state so the gate sees a
  // glitch-free pulse aligned exactly with the PRECH cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_precharge <= 1'b0;
    end else begin
      r_precharge <= (w_state_nxt == PRECH);
    end
  end

  // Evaluation cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_eval_cnt <= '0;
    end else if (w_load_eval) begin
      r_eval_cnt <= LP_EVAL_LOAD;
    end else if (r_state == EVAL && r_eval_cnt != '0) begin
      r_eval_cnt <= r_eval_cnt - 1'b1;
    end
  end

  // Operand and mask capture; held from accept until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_in0 <= 1'b0;
      r_gate_in1 <= 1'b0;
      r_m_in0    <= 1'b0;
      r_m_in1    <= 1'b0;
      r_m_out    <= 1'b0;
    end else if (w_accept) begin
      r_gate_in0 <= in0_data;
      r_gate_in1 <= in1_data;
      r_m_in0    <= prng_in[0];
      r_m_in1    <= prng_in[1];
      r_m_out    <= prng_in[2];
    end
  end

  // Result capture at the end of evaluation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_masked <= 1'b0;
      r_out_mask   <= 1'b0;
    end else if (w_capture) begin
      r_out_masked <= gate_out;
      r_out_mask   <= r_m_out;
    end
  end

  // Completed-transaction counter, counted on consumer handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txn_count <= '0;
    end else if (w_retire) begin
      r_txn_count <= r_txn_count + CNT_W'(1);
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign out_valid  = (r_state == DONE);
  assign precharge  = r_precharge;
  assign gate_in0   = r_gate_in0;
  assign gate_in1   = r_gate_in1;
  assign m_in0      = r_m_in0;
  assign m_in1      = r_m_in1;
  assign m_out      = r_m_out;
  assign out_masked = r_out_masked;
  assign out_mask   = r_out_mask;
  assign out_data   = r_out_masked ^ r_out_mask;
  assign txn_count  = r_txn_count;

endmodule
